fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
// Decoupling FIFO between the IF stage and the decode stage. Each accepted IF beat
// carries two fetched packets; the queue stores them as separate entries. Decode
// drains zero, one or two entries per cycle, in program order.
// A flush from the back-end empties the queue so wrong-path packets never reach decode.
// PARAMETERS
// PACKET_SIZE  64  width of one fetched packet (pc, data, taken_branch), treated as opaque
// DEPTH        8   number of packet entries; power of two, >= 4
// PORTS
// clk          in   1              clock
// rst_n        in   1              reset, asynchronous, active-low
// data_i       in   2*PACKET_SIZE  IF beat: [PACKET_SIZE-1:0] = older packet A, upper half = packet B
// valid_i      in   1              IF beat valid
// ready_o      out  1              queue can accept a full beat this cycle
// flush_i      in   1              discard all stored entries (must_flush from back-end)
// packet_a_o   out  PACKET_SIZE    head entry
// valid_a_o    out  1              head entry valid
// ready_a_i    in   1              decode consumes head entry
// packet_b_o   out  PACKET_SIZE    head+1 entry
// valid_b_o    out  1              head+1 entry valid
// ready_b_i    in   1              decode consumes head+1 entry; honoured only with ready_a_i
// count_o      out  $clog2(DEPTH+1) current occupancy, registered
// BEHAVIOUR
// - Reset (async): head/tail pointers = 0; count = 0; valid_a_o = valid_b_o = 0;
//   ready_o = 1; count_o = 0. Entry storage is not reset.
// - ready_o = (count <= DEPTH-2). It depends on registered count only; pops in the
//   same cycle do not raise it (no combinational ready path).
// - Push: push = valid_i & ready_o & ~flush_i. On push, write packet A at tail and
//   packet B at tail+1; tail += 2 (mod DEPTH).
//   valid_i & ~ready_o means the beat is not accepted; IF must hold data_i stable.
// - Outputs: packet_a_o = mem[head] and packet_b_o = mem[head+1 mod DEPTH], read combinationally.
//   valid_a_o = (count >= 1); valid_b_o = (count >= 2).
// - Pop: pop_a = valid_a_o & ready_a_i & ~flush_i; pop_b = pop_a & valid_b_o & ready_b_i.
//   head += pop_a + pop_b (mod DEPTH).
//   ready_b_i without ready_a_i pops nothing (in-order rule).
// - Count: count_next = count + 2*push - pop_a - pop_b. It never exceeds DEPTH and
//   never goes below 0. Width is $clog2(DEPTH+1); pointers are $clog2(DEPTH) bits and
//   wrap naturally.
// - Latency: a beat pushed in cycle N is visible on packet_a_o/valid_a_o in cycle N+1.
//   There is no bypass when the queue is empty.
// - Simultaneous push and pop: both are allowed in the same cycle.
//   Full case: at count = DEPTH-2, push + 2 pops gives count = DEPTH-2.
//   Empty case: pops act on old contents only; newly pushed entries appear next cycle.
// - Flush: highest priority. Next cycle head = tail = count = 0, and any push or pop
//   in the flush cycle is discarded. valid_a_o/valid_b_o may still be high during the
//   flush cycle; decode ignores them, since flush_i gates pop.
// - Reset asserted mid-operation clears all state immediately. No entry survives reset.
// - No state machine beyond the pointers and count. ready_o/valid_*_o glitch-free (registered count).
// TESTING
// - Reset: after rst_n rises -> count_o=0, valid_a_o=0, valid_b_o=0, ready_o=1.
// - Fill: 4 beats with ready_a_i=0 (pc 0x0/0x4 .. 0x18/0x1C) -> count_o=8, ready_o=0;
//   5th beat held, not written.
// - Order/partial drain: after fill, ready_a_i=1, ready_b_i=0 for 1 cycle -> pc 0x0 popped,
//   next head pc=0x4, count_o=7, ready_o still 0 until count<=6.
// - Wrap + simultaneous: steady state, push every cycle and pop 2 every cycle for 20 cycles ->
//   pc sequence strictly +4 across pointer wrap, count_o constant.
// - ready_b_i=1 with ready_a_i=0 -> no pop; count_o unchanged.
// - Flush with count=6 and push+pop same cycle -> next cycle count_o=0, valid_a_o=0;
//   the next beat pushed appears at head 1 cycle later.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Interface bundling the IF-side beat handshake, the flush request and the
// two-wide decode-side drain ports of the fetch queue. Signal names are given
// from the queue's point of view (_i = into the queue, _o = out of the queue).
interface fetch_queue_if #(
  parameter int PACKET_SIZE = 64,
  parameter int DEPTH       = 8
);

  localparam int CW = $clog2(DEPTH + 1);

  // IF stage beat: two packets, older one in the low half
  logic [2*PACKET_SIZE-1:0] data_i;
  logic                     valid_i;
  logic                     ready_o;

  // Back-end flush request
  logic                     flush_i;

  // Decode stage drain, head entry
  logic [PACKET_SIZE-1:0]   packet_a_o;
  logic                     valid_a_o;
  logic                     ready_a_i;

  // Decode stage drain, head+1 entry
  logic [PACKET_SIZE-1:0]   packet_b_o;
  logic                     valid_b_o;
  logic                     ready_b_i;

  // Registered occupancy
  logic [CW-1:0]            count_o;

  // Driver side: IF stage, back-end and decode stage together
  modport master (
    output data_i,
    output valid_i,
    input  ready_o,
    output flush_i,
    input  packet_a_o,
    input  valid_a_o,
    output ready_a_i,
    input  packet_b_o,
    input  valid_b_o,
    output ready_b_i,
    input  count_o
  );

  // Queue side
  modport slave (
    input  data_i,
    input  valid_i,
    output ready_o,
    input  flush_i,
    output packet_a_o,
    output valid_a_o,
    input  ready_a_i,
    output packet_b_o,
    output valid_b_o,
    input  ready_b_i,
    output count_o
  );

endinterface

// File: rtl/fetch_queue.sv
// Decoupling FIFO between IF and decode. Each accepted IF beat writes two
// packet entries; decode drains up to two entries per cycle in program order.
// A flush empties the queue so wrong-path packets never reach decode.
// All handshake outputs derive from registered pointers/count only, so there
// is no combinational path from the decode ready inputs to ready_o.
module fetch_queue #(
  parameter int PACKET_SIZE = 64,
  parameter int DEPTH       = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_queue_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Entry storage, deliberately left out of reset
  logic [PACKET_SIZE-1:0] mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [PW-1:0] head_plus1;
  logic [PW-1:0] tail_plus1;

  logic          ready;
  logic          valid_a;
  logic          valid_b;
  logic          push;
  logic          pop_a;
  logic          pop_b;
  logic [1:0]    pop_cnt;

  // Handshake qualifiers derived from the registered count and the inputs
  always_comb begin
    head_plus1 = head_q + PW'(1);
    tail_plus1 = tail_q + PW'(1);
    ready      = (count_q <= CW'(DEPTH - 2));
    valid_a    = (count_q >= CW'(1));
    valid_b    = (count_q >= CW'(2));
    push       = bus.valid_i & ready & ~bus.flush_i;
    pop_a      = valid_a & bus.ready_a_i & ~bus.flush_i;
    pop_b      = pop_a & valid_b & bus.ready_b_i;
    pop_cnt    = {1'b0, pop_a} + {1'b0, pop_b};
  end

  // Next-state pointers and occupancy; flush overrides any push or pop
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(pop_cnt);
      tail_d  = push ? (tail_q + PW'(2)) : tail_q;
      count_d = count_q + (push ? CW'(2) : CW'(0)) - CW'(pop_cnt);
    end
  end

  // Pointer and count registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Write both packets of an accepted beat at tail and tail+1
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q]     <= bus.data_i[PACKET_SIZE-1:0];
      mem_q[tail_plus1] <= bus.data_i[2*PACKET_SIZE-1:PACKET_SIZE];
    end
  end

  // Outputs: head entries are read straight from storage, no empty bypass
  always_comb begin
    bus.ready_o    = ready;
    bus.valid_a_o  = valid_a;
    bus.valid_b_o  = valid_b;
    bus.packet_a_o = mem_q[head_q];
    bus.packet_b_o = mem_q[head_plus1];
    bus.count_o    = count_q;
  end

  // Occupancy must stay within the storage capacity
  assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));

  // A held beat must never be written while the queue is too full to take it
  assert property (@(posedge clk) disable iff (!rst_n)
                   (count_q > CW'(DEPTH - 2)) |-> !push);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue: reset, fill/backpressure, partial drain,
// in-order rule, wrap with simultaneous push/pop, flush and mid-run reset.
module tb_fetch_queue;

  localparam int PS = 64;
  localparam int DP = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  fetch_queue_if #(.PACKET_SIZE(PS), .DEPTH(DP)) bus ();

  fetch_queue #(.PACKET_SIZE(PS), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packet encoding: pc in the low word, a pc-derived tag in the high word
  function automatic logic [PS-1:0] mk(input logic [31:0] pc);
    return {pc ^ 32'hC0DE_0000, pc};
  endfunction

  function automatic logic [2*PS-1:0] beat(input logic [31:0] pc);
    return {mk(pc + 32'd4), mk(pc)};
  endfunction

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.data_i    = '0;
    bus.valid_i   = 1'b0;
    bus.flush_i   = 1'b0;
    bus.ready_a_i = 1'b0;
    bus.ready_b_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.count_o !== 4'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", bus.count_o); end
    total++; if (bus.valid_a_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid_a got=%0b want=0", bus.valid_a_o); end
    total++; if (bus.valid_b_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid_b got=%0b want=0", bus.valid_b_o); end
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%0b want=1", bus.ready_o); end
  endtask

  task automatic test_fill();
    bus.ready_a_i = 1'b0;
    bus.ready_b_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.valid_i = 1'b1;
      bus.data_i  = beat(32'(i * 8));
      @(negedge clk);
      total++; if (bus.count_o !== 4'(2 * (i + 1))) begin bad++; $display("[TB] FAIL fill_count%0d got=%0d want=%0d", i, bus.count_o, 2 * (i + 1)); end
      total++; if (bus.ready_o !== ((i < 3) ? 1'b1 : 1'b0)) begin bad++; $display("[TB] FAIL fill_ready%0d got=%0b want=%0b", i, bus.ready_o, (i < 3)); end
    end
    total++; if (bus.valid_a_o !== 1'b1) begin bad++; $display("[TB] FAIL fill_valid_a got=%0b want=1", bus.valid_a_o); end
    total++; if (bus.valid_b_o !== 1'b1) begin bad++; $display("[TB] FAIL fill_valid_b got=%0b want=1", bus.valid_b_o); end
    total++; if (bus.packet_a_o !== mk(32'h0)) begin bad++; $display("[TB] FAIL fill_pkt_a got=%0h want=%0h", bus.packet_a_o, mk(32'h0)); end
    total++; if (bus.packet_b_o !== mk(32'h4)) begin bad++; $display("[TB] FAIL fill_pkt_b got=%0h want=%0h", bus.packet_b_o, mk(32'h4)); end
    // Fifth beat is held while full; it must not overwrite the head entries
    bus.valid_i = 1'b1;
    bus.data_i  = beat(32'h20);
    @(negedge clk);
    total++; if (bus.count_o !== 4'd8) begin bad++; $display("[TB] FAIL held_count got=%0d want=8", bus.count_o); end
    total++; if (bus.packet_a_o !== mk(32'h0)) begin bad++; $display("[TB] FAIL held_pkt_a got=%0h want=%0h", bus.packet_a_o, mk(32'h0)); end
    total++; if (bus.packet_b_o !== mk(32'h4)) begin bad++; $display("[TB] FAIL held_pkt_b got=%0h want=%0h", bus.packet_b_o, mk(32'h4)); end
  endtask

  task automatic test_partial_drain();
    // Beat 0x20 stays offered throughout
    bus.ready_a_i = 1'b1;
    bus.ready_b_i = 1'b0;
    @(negedge clk);
    total++; if (bus.count_o !== 4'd7) begin bad++; $display("[TB] FAIL drain1_count got=%0d want=7", bus.count_o); end
    total++; if (bus.packet_a_o !== mk(32'h4)) begin bad++; $display("[TB] FAIL drain1_pkt_a got=%0h want=%0h", bus.packet_a_o, mk(32'h4)); end
    total++; if (bus.packet_b_o !== mk(32'h8)) begin bad++; $display("[TB] FAIL drain1_pkt_b got=%0h want=%0h", bus.packet_b_o, mk(32'h8)); end
    total++; if (bus.ready_o !== 1'b0) begin bad++; $display("[TB] FAIL drain1_ready got=%0b want=0", bus.ready_o); end
    @(negedge clk);
    total++; if (bus.count_o !== 4'd6) begin bad++; $display("[TB] FAIL drain2_count got=%0d want=6", bus.count_o); end
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("[TB] FAIL drain2_ready got=%0b want=1", bus.ready_o); end
    total++; if (bus.packet_a_o !== mk(32'h8)) begin bad++; $display("[TB] FAIL drain2_pkt_a got=%0h want=%0h", bus.packet_a_o, mk(32'h8)); end
    // Now the held beat is accepted
    bus.ready_a_i = 1'b0;
    @(negedge clk);
    bus.valid_i = 1'b0;
    total++; if (bus.count_o !== 4'd8) begin bad++; $display("[TB] FAIL accept_count got=%0d want=8", bus.count_o); end
    total++; if (bus.packet_a_o !== mk(32'h8)) begin bad++; $display("[TB] FAIL accept_pkt_a got=%0h want=%0h", bus.packet_a_o, mk(32'h8)); end
  endtask

  task automatic test_b_without_a();
    bus.ready_a_i = 1'b0;
    bus.ready_b_i = 1'b1;
    @(negedge clk);
    total++; if (bus.count_o !== 4'd8) begin bad++; $display("[TB] FAIL bonly_count got=%0d want=8", bus.count_o); end
    total++; if (bus.packet_a_o !== mk(32'h8)) begin bad++; $display("[TB] FAIL bonly_pkt_a got=%0h want=%0h", bus.packet_a_o, mk(32'h8)); end
    bus.ready_a_i = 1'b1;
    bus.ready_b_i = 1'b1;
    @(negedge clk);
    total++; if (bus.count_o !== 4'd6) begin bad++; $display("[TB] FAIL pop2_count got=%0d want=6", bus.count_o); end
    total++; if (bus.packet_a_o !== mk(32'h10)) begin bad++; $display("[TB] FAIL pop2_pkt_a got=%0h want=%0h", bus.packet_a_o, mk(32'h10)); end
    total++; if (bus.packet_b_o !== mk(32'h14)) begin bad++; $display("[TB] FAIL pop2_pkt_b got=%0h want=%0h", bus.packet_b_o, mk(32'h14)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] head_pc;
    logic [31:0] next_pc;
    head_pc = 32'h10;
    next_pc = 32'h28;
    for (int k = 0; k < 20; k++) begin
      total++; if (bus.count_o !== 4'd6) begin bad++; $display("[TB] FAIL b2b_count%0d got=%0d want=6", k, bus.count_o); end
      total++; if (bus.packet_a_o !== mk(head_pc)) begin bad++; $display("[TB] FAIL b2b_pkt_a%0d got=%0h want=%0h", k, bus.packet_a_o, mk(head_pc)); end
      total++; if (bus.packet_b_o !== mk(head_pc + 32'd4)) begin bad++; $display("[TB] FAIL b2b_pkt_b%0d got=%0h want=%0h", k, bus.packet_b_o, mk(head_pc + 32'd4)); end
      bus.valid_i   = 1'b1;
      bus.data_i    = beat(next_pc);
      bus.ready_a_i = 1'b1;
      bus.ready_b_i = 1'b1;
      next_pc       = next_pc + 32'd8;
      head_pc       = head_pc + 32'd8;
      @(negedge clk);
    end
    total++; if (bus.count_o !== 4'd6) begin bad++; $display("[TB] FAIL b2b_final_count got=%0d want=6", bus.count_o); end
    total++; if (bus.packet_a_o !== mk(head_pc)) begin bad++; $display("[TB] FAIL b2b_final_pkt_a got=%0h want=%0h", bus.packet_a_o, mk(head_pc)); end
  endtask

  task automatic test_flush();
    // Flush with push and double pop offered in the same cycle
    bus.flush_i   = 1'b1;
    bus.valid_i   = 1'b1;
    bus.data_i    = beat(32'h5000);
    bus.ready_a_i = 1'b1;
    bus.ready_b_i = 1'b1;
    @(negedge clk);
    total++; if (bus.count_o !== 4'd0) begin bad++; $display("[TB] FAIL flush_count got=%0d want=0", bus.count_o); end
    total++; if (bus.valid_a_o !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid_a got=%0b want=0", bus.valid_a_o); end
    total++; if (bus.valid_b_o !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid_b got=%0b want=0", bus.valid_b_o); end
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("[TB] FAIL flush_ready got=%0b want=1", bus.ready_o); end
    bus.flush_i   = 1'b0;
    bus.data_i    = beat(32'h1000);
    bus.ready_a_i = 1'b0;
    bus.ready_b_i = 1'b0;
    @(negedge clk);
    bus.valid_i = 1'b0;
    total++; if (bus.count_o !== 4'd2) begin bad++; $display("[TB] FAIL postflush_count got=%0d want=2", bus.count_o); end
    total++; if (bus.valid_a_o !== 1'b1) begin bad++; $display("[TB] FAIL postflush_valid_a got=%0b want=1", bus.valid_a_o); end
    total++; if (bus.packet_a_o !== mk(32'h1000)) begin bad++; $display("[TB] FAIL postflush_pkt_a got=%0h want=%0h", bus.packet_a_o, mk(32'h1000)); end
    total++; if (bus.packet_b_o !== mk(32'h1004)) begin bad++; $display("[TB] FAIL postflush_pkt_b got=%0h want=%0h", bus.packet_b_o, mk(32'h1004)); end
  endtask

  task automatic test_empty_simul();
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    total++; if (bus.valid_a_o !== 1'b0) begin bad++; $display("[TB] FAIL empty_valid_a got=%0b want=0", bus.valid_a_o); end
    // Push into an empty queue while decode is ready: nothing to pop yet
    bus.valid_i   = 1'b1;
    bus.data_i    = beat(32'h2000);
    bus.ready_a_i = 1'b1;
    bus.ready_b_i = 1'b1;
    @(negedge clk);
    bus.valid_i   = 1'b0;
    bus.ready_a_i = 1'b0;
    bus.ready_b_i = 1'b0;
    total++; if (bus.count_o !== 4'd2) begin bad++; $display("[TB] FAIL empty_push_count got=%0d want=2", bus.count_o); end
    total++; if (bus.packet_a_o !== mk(32'h2000)) begin bad++; $display("[TB] FAIL empty_push_pkt_a got=%0h want=%0h", bus.packet_a_o, mk(32'h2000)); end
  endtask

  task automatic test_reset_mid();
    bus.valid_i = 1'b1;
    bus.data_i  = beat(32'h3000);
    @(negedge clk);
    bus.valid_i = 1'b0;
    total++; if (bus.count_o !== 4'd4) begin bad++; $display("[TB] FAIL premid_count got=%0d want=4", bus.count_o); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.count_o !== 4'd0) begin bad++; $display("[TB] FAIL midrst_count got=%0d want=0", bus.count_o); end
    total++; if (bus.valid_a_o !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid_a got=%0b want=0", bus.valid_a_o); end
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("[TB] FAIL midrst_ready got=%0b want=1", bus.ready_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.count_o !== 4'd0) begin bad++; $display("[TB] FAIL postrst_count got=%0d want=0", bus.count_o); end
  endtask

  // Run every scenario in order, then report
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fill();
    test_partial_drain();
    test_b_without_a();
    test_back_to_back();
    test_flush();
    test_empty_simul();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
